// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a circular FIFO,
// serialized as back-to-back frames with a sent-frame counter and sticky overflow flag.
module uart_tx_buffered #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 100000,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     serial_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              sent_count,
  output logic                     overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg;
  logic            tx_reg, tx_next;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic [15:0]     sent_count_reg, sent_count_next;
  logic            overflow_reg;
  logic [7:0]      fifo_mem [DEPTH];

  logic push, pop, shift_en, frame_done, timer_done;

  assign in_ready   = (count_reg != COUNT_FULL);
  assign push       = in_valid && in_ready;
  assign serial_tx  = tx_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count = count_reg;
  assign sent_count = sent_count_reg;
  assign overflow   = overflow_reg;

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_idx_next = bit_idx_reg;
    tx_next      = 1'b1;
    pop          = 1'b0;
    shift_en     = 1'b0;
    frame_done   = 1'b0;
    timer_done   = (timer_reg == TIMER_LAST);
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          timer_next = '0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (timer_done) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (timer_done) begin
          timer_next   = '0;
          shift_en     = 1'b1;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      STOP: begin
        if (timer_done) begin
          timer_next = '0;
          frame_done = 1'b1;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sent_count_next = frame_done ? sent_count_reg + 16'd1 : sent_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_idx_reg    <= '0;
      tx_reg         <= 1'b1;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      sent_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      bit_idx_reg    <= bit_idx_next;
      tx_reg         <= tx_next;
      sent_count_reg <= sent_count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + (PW+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PW+1)'(1);
      if (in_valid && !in_ready) overflow_reg <= 1'b1;
    end
  end

  // Storage and shifter carry no reset; the head byte is read straight into the shifter.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (pop)           shift_reg <= fifo_mem[rd_ptr_reg];
    else if (shift_en) shift_reg <= {1'b0, shift_reg[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and randomized checks of uart_tx_buffered against an arithmetic frame model
// and a line decoder that recovers bytes and start-bit times from serial_tx.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 400;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 16;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int FRAME    = 10 * CPB;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        serial_tx;
  logic        busy;
  logic [4:0]  fifo_count;
  logic [15:0] sent_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_sent = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];
  int         frame_err = 0;

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .serial_tx(serial_tx), .busy(busy),
    .fifo_count(fifo_count), .sent_count(sent_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit on the falling clock edge.
  logic       mon_active = 1'b0;
  logic       mon_prev = 1'b1;
  int         mon_k = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (mon_prev && !serial_tx) begin
        mon_active = 1'b1;
        mon_k = 0;
        mon_byte = 8'h00;
        start_q.push_back(cyc);
      end
    end else begin
      mon_k++;
      if (mon_k == HALF && serial_tx !== 1'b0) frame_err++;
      if (mon_k > HALF && ((mon_k - HALF) % CPB) == 0) begin
        int b;
        b = (mon_k - HALF) / CPB;
        if (b >= 1 && b <= 8) mon_byte[b-1] = serial_tx;
        if (b == 9) begin
          if (serial_tx !== 1'b1) frame_err++;
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
    mon_prev = serial_tx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_sent = 0;
    rx_q.delete();
    start_q.delete();
    exp_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
    repeat (CPB + 2) tick();
  endtask

  // Expected line level t edges after the accepting edge, from the frame layout alone.
  function automatic logic exp_tx(input int t, input logic [7:0] b);
    int k;
    k = t - 2;
    if (k < 0 || k >= FRAME) return 1'b1;
    if (k / CPB == 0) return 1'b0;
    if (k / CPB == 9) return 1'b1;
    return b[k / CPB - 1];
  endfunction

  task automatic single_frame(input logic [7:0] b);
    string tag;
    in_data = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_count_e0", 32'(fifo_count), 32'd1);
    check("single_tx_t0", 32'(serial_tx), 32'(exp_tx(0, b)));
    for (int t = 1; t <= FRAME + 4; t++) begin
      tick();
      tag = $sformatf("single_%02h_tx_t%0d", b, t);
      check(tag, 32'(serial_tx), 32'(exp_tx(t, b)));
      if (t == 1) check("single_count_pop", 32'(fifo_count), 32'd0);
      if (t == FRAME) begin
        check("single_sent_before", 32'(sent_count), 32'(exp_sent & 16'hFFFF));
        check("single_busy_before", 32'(busy), 32'd1);
      end
      if (t == FRAME + 1) begin
        exp_sent++;
        check("single_sent_after", 32'(sent_count), 32'(exp_sent & 16'hFFFF));
        check("single_busy_after", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    check({tag, "_framing"}, 32'(frame_err), 32'd0);
    check({tag, "_sent"}, 32'(sent_count), 32'(exp_sent & 16'hFFFF));
  endtask

  initial begin
    int tx_low;
    logic [7:0] r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;

    // Reset state
    do_reset();
    check("rst_tx", 32'(serial_tx), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_sent", 32'(sent_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single frames: 0x55 then random bytes
    single_frame(8'h55);
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      single_frame(r);
    end
    $display("single frames done, sent=%0d", sent_count);

    // Burst of 20 into a 16-deep FIFO
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i);
      tick();
      if (i < 17) exp_q.push_back(8'(i));
      if (i == 15) check("burst_ready_e15", 32'(in_ready), 32'd1);
      if (i == 16) begin
        check("burst_ready_e16", 32'(in_ready), 32'd0);
        check("burst_count_full", 32'(fifo_count), 32'(DEPTH));
        check("burst_ovf_e16", 32'(overflow), 32'd0);
      end
      if (i == 17) check("burst_ovf_e17", 32'(overflow), 32'd1);
    end
    in_valid = 1'b0;
    wait_idle(17 * FRAME + 100);
    exp_sent = 17;
    check_rx("burst");
    for (int i = 0; i + 1 < start_q.size(); i++)
      check($sformatf("burst_gap%0d", i), 32'(start_q[i+1] - start_q[i]), 32'(FRAME));
    check("burst_ovf_sticky", 32'(overflow), 32'd1);
    $display("burst done, frames=%0d sent=%0d", rx_q.size(), sent_count);

    // Back-to-back pair
    do_reset();
    in_valid = 1'b1;
    in_data = 8'hA5; tick();
    in_data = 8'h3C; tick();
    in_valid = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_sent = 2;
    wait_idle(3 * FRAME);
    check_rx("pair");
    check("pair_starts", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("pair_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));
    $display("pair done, gap=%0d", start_q.size() == 2 ? start_q[1] - start_q[0] : -1);

    // Random bytes with random gaps (never enough to fill the FIFO)
    do_reset();
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom);
      in_data = r;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_q.push_back(r);
      repeat ($urandom_range(0, 3)) tick();
    end
    exp_sent = 12;
    wait_idle(13 * FRAME);
    check_rx("random");
    for (int i = 0; i + 1 < start_q.size(); i++)
      check($sformatf("random_gap%0d", i), 32'(start_q[i+1] - start_q[i]), 32'(FRAME));
    $display("random done, frames=%0d", rx_q.size());

    // Reset during DATA of the first of three queued frames
    do_reset();
    in_valid = 1'b1;
    in_data = 8'hFF; tick();
    in_data = 8'h00; tick();
    in_data = 8'h0F; tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rx_q.delete();
    start_q.delete();
    check("abort_tx", 32'(serial_tx), 32'd1);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_sent", 32'(sent_count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    tx_low = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      tick();
      if (serial_tx !== 1'b1) tx_low++;
    end
    check("abort_tx_low_cycles", 32'(tx_low), 32'd0);
    check("abort_frames", 32'(start_q.size()), 32'd0);
    check("abort_sent_end", 32'(sent_count), 32'd0);
    $display("abort done, low_cycles=%0d", tx_low);

    // Counter wrap via backdoor preload
    do_reset();
    @(negedge clk);
    force dut.sent_count_reg = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.sent_count_reg;
    tick();
    check("wrap_preload", 32'(sent_count), 32'h0000FFFF);
    r = 8'($urandom);
    in_data = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(r);
    exp_sent = 32'h10000;
    wait_idle(2 * FRAME);
    check_rx("wrap");
    $display("wrap done, sent=%0h", sent_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
